// File: rtl/mdu_riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM states and small op-decoding helpers.
package mdu_riscv_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_riscv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator, one operand register and a counter.
module mdu_riscv
    import mdu_riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_lo_q;
    logic              neg_rem_q;
    logic [XLEN-1:0]   res_q;

    // Accept-time decode
    mdu_op_e         op_in;
    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div_in, div_zero, div_ovf, special;
    logic            accept;

    always_comb begin
        op_in     = mdu_op_e'(op_i);
        sa        = op_a_signed(op_in) & a_i[XLEN-1];
        sb        = op_b_signed(op_in) & b_i[XLEN-1];
        a_mag     = sa ? -a_i : a_i;
        b_mag     = sb ? -b_i : b_i;
        is_div_in = op_is_div(op_in);
        div_zero  = is_div_in && (b_i == '0);
        div_ovf   = is_div_in && op_b_signed(op_in) && (a_i == MIN_INT) && (b_i == '1);
        special   = div_zero || div_ovf;
        accept    = valid_i && ready_o && !flush_i;
    end

    // One iteration step of each algorithm
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[XLEN];
        div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
    end

    // Final sign correction and result selection, used in DONE
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, done_result;

    always_comb begin
        prod = neg_lo_q ? -acc_q : acc_q;
        quo  = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            MDU_MUL:                      done_result = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: done_result = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:            done_result = quo;
            default:                      done_result = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush_i)
                    state_d = ST_IDLE;
                else if (cnt_q == CW'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= MDU_MUL;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_in;
                opnd_q <= b_mag;
                cnt_q  <= special ? '0 : CW'(XLEN);
                // Special cases preload {remainder, quotient} so DONE needs no extra path
                if (div_zero) begin
                    acc_q     <= {a_i, {XLEN{1'b1}}};
                    neg_lo_q  <= 1'b0;
                    neg_rem_q <= 1'b0;
                end else if (div_ovf) begin
                    acc_q     <= {{XLEN{1'b0}}, MIN_INT};
                    neg_lo_q  <= 1'b0;
                    neg_rem_q <= 1'b0;
                end else begin
                    acc_q     <= {{XLEN{1'b0}}, a_mag};
                    neg_lo_q  <= sa ^ sb;
                    neg_rem_q <= is_div_in & sa;
                end
            end else if (state_q == ST_CALC && !flush_i) begin
                acc_q <= op_is_div(op_q) ? div_next : mul_next;
                cnt_q <= cnt_q - CW'(1);
            end

            if (state_q == ST_DONE && !flush_i)
                res_q <= done_result;
        end
    end

    // result_o shows the fresh value during the DONE pulse, then holds it
    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE) && !flush_i;
    assign result_o = valid_o ? done_result : res_q;

endmodule

// File: tb/tb_mdu_riscv.sv
// Directed bench for mdu_riscv: table of RV32M vectors plus abort,
// reset and busy-request sequences.
module tb_mdu_riscv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    mdu_riscv #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue at cycle T, expect valid_o after lat cycles with ready_o low throughout
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string nm);
        int   n;
        logic busy_ok;
        check({nm, " ready_before"}, 32'(ready_o), 32'd1);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        op_i    = ~op;
        a_i     = ~a;
        b_i     = a ^ b ^ 32'h5A5A_0F0F;
        n       = 1;
        busy_ok = 1'b1;
        while (!valid_o && n < 200) begin
            if (ready_o) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (ready_o) busy_ok = 1'b0;
        check({nm, " latency"}, 32'(n), 32'(lat));
        check({nm, " result"}, result_o, exp);
        check({nm, " busy"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({nm, " ready_after"}, 32'(ready_o), 32'd1);
        check({nm, " hold"}, result_o, exp);
    endtask

    initial begin
        int   n;
        logic seen;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3"};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH -1*-1"};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU -1*max"};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max"};
        vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min"};
        vecs[5]  = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33, "MULHU 2^31*2"};
        vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "DIV -7/2"};
        vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "REM -7/2"};
        vecs[8]  = '{3'b101, 32'd100,       32'd7,        32'd14,        33, "DIVU 100/7"};
        vecs[9]  = '{3'b111, 32'd100,       32'd7,        32'd2,         33, "REMU 100/7"};
        vecs[10] = '{3'b100, 32'h1234_5678, 32'h0,        32'hFFFF_FFFF, 1,  "DIV by 0"};
        vecs[11] = '{3'b101, 32'h1234_5678, 32'h0,        32'hFFFF_FFFF, 1,  "DIVU by 0"};
        vecs[12] = '{3'b110, 32'h1234_5678, 32'h0,        32'h1234_5678, 1,  "REM by 0"};
        vecs[13] = '{3'b111, 32'h1234_5678, 32'h0,        32'h1234_5678, 1,  "REMU by 0"};
        vecs[14] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf"};
        vecs[15] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "REM ovf"};
        vecs[16] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2"};
        vecs[17] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "REM 7/-2"};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'b000;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset ready", 32'(ready_o), 32'd1);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset result", result_o, 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        // Flush in CALC at T+10: no result, previous result kept
        do_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "pre-flush DIVU");
        op_i = 3'b100; a_i = 32'hFFFF_FFF9; b_i = 32'd2; valid_i = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (valid_o) seen = 1'b1;
            if (k == 10) flush_i = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b0;
        check("flush ready T+11", 32'(ready_o), 32'd1);
        check("flush valid T+11", 32'(valid_o), 32'd0);
        check("flush result kept", result_o, 32'd14);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("flush no valid", 32'(seen), 32'd0);

        // Reset at T+5 of a MUL
        op_i = 3'b000; a_i = 32'd7; b_i = 32'hFFFF_FFFD; valid_i = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (valid_o) seen = 1'b1;
            if (k == 5) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset ready", 32'(ready_o), 32'd1);
        check("midreset valid", 32'(valid_o), 32'd0);
        check("midreset result", result_o, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("midreset no valid", 32'(seen), 32'd0);

        // Flush during the DONE cycle of a special case
        do_op(3'b111, 32'd100, 32'd7, 32'd2, 33, "pre-doneflush REMU");
        op_i = 3'b100; a_i = 32'd5; b_i = 32'd0; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("doneflush valid", 32'(valid_o), 32'd0);
        check("doneflush result", result_o, 32'd2);
        @(negedge clk);
        flush_i = 1'b0;
        check("doneflush ready", 32'(ready_o), 32'd1);
        check("doneflush kept", result_o, 32'd2);

        // Flush in IDLE blocks a simultaneous request
        op_i = 3'b101; a_i = 32'd9; b_i = 32'd0; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("idleflush ready", 32'(ready_o), 32'd1);
        check("idleflush valid", 32'(valid_o), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("idleflush no valid", 32'(seen), 32'd0);

        // Request held while busy: ignored until ready_o returns, then accepted
        op_i = 3'b000; a_i = 32'd7; b_i = 32'hFFFF_FFFD; valid_i = 1'b1;
        @(negedge clk);
        op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
        n = 1;
        while (!valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy first latency", 32'(n), 32'd33);
        check("busy first result", result_o, 32'hFFFF_FFEB);
        @(negedge clk);
        check("busy reaccept ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        op_i = 3'b000; a_i = '0; b_i = '0;
        check("busy second accepted", 32'(ready_o), 32'd0);
        n = 1;
        while (!valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy second latency", 32'(n), 32'd33);
        check("busy second result", result_o, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_riscv.md
Name: mdu_riscv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
- Consumes the same register-file operands (A, B) and produces a result for the writeback mux.
- The decoder raises valid_i for M-extension instructions and stalls the pipeline while ready_o is low.
- One operation in flight at a time; shift-add multiply and restoring divide.

Parameters:
XLEN, 32, operand/result width; the counter width is clog2(XLEN)+1.

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
valid_i  input  1  request; accepted on a cycle where valid_i && ready_o
op_i  input  3  operation, encoded as funct3 (MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111)
a_i  input  XLEN  operand A (rs1)
b_i  input  XLEN  operand B (rs2)
flush_i  input  1  synchronous abort of the operation in flight
ready_o  output  1  high only in IDLE
valid_o  output  1  one-cycle pulse, result_o valid
result_o  output  XLEN  result; held until the next valid_o

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge), including mid-operation:
  - state=IDLE, ready_o=1, valid_o=0, result_o=0, counter=0.
  - Any in-flight operation is discarded and produces no valid_o.
- State machine IDLE -> CALC -> DONE -> IDLE:
  - IDLE: on accept at cycle T, latch op, operand magnitudes, sign flags and special-case flags.
    - Special case: next state is DONE.
    - Otherwise: next state is CALC with counter=XLEN.
  - CALC: one iteration per cycle; counter decrements; at counter==1 the next state is DONE.
  - DONE: valid_o=1 for exactly this cycle; result_o updates in the same cycle; next state is IDLE.
- Latency:
  - Normal operations: valid_o asserts at T+XLEN+1 (T+33 for XLEN=32).
  - Special cases: valid_o asserts at T+1.
  - Throughput: one operation per XLEN+2 cycles. ready_o is low from T+1 until the cycle after DONE.
- Multiply:
  - Operand magnitudes are taken per signedness: MULH both signed; MULHSU A signed, B unsigned; MUL and MULHU unsigned.
  - 2*XLEN-bit shift-add accumulation.
  - The product is negated when the signed-operand signs differ.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated if sign(A)^sign(B) for signed ops.
  - Remainder takes the sign of the dividend.
- Special cases (1-cycle path, per RISC-V spec):
  - b_i==0: quotient = all ones (0xFFFFFFFF); remainder = a_i. Applies to signed and unsigned ops.
  - DIV/REM with a_i=0x80000000 and b_i=0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Multiply has no special cases.
- flush_i:
  - In CALC or DONE: next state is IDLE, valid_o is suppressed, result_o is unchanged.
  - In IDLE: any simultaneous valid_i is ignored (not accepted).
  - flush_i has priority over accept; rst_n has priority over everything.
- valid_i while busy: ignored. The requester must hold the request until ready_o is high.
- Operands are latched at accept; later changes on a_i, b_i or op_i have no effect.

Decomposition:
- Op-code macros MDU_MUL..MDU_REMU (3-bit, funct3 values) and the state encodings go in the shared defines_riscv.v, next to the ALU op macros.
- No sub-module is needed: the multiply and divide iteration steps are small and sit inline in one datapath.
- Only a 2XLEN accumulator/remainder register, one XLEN operand register and a counter are shared between multiply and divide.

Test Plan:
- MUL 7*(-3): a=0x00000007, b=0xFFFFFFFD -> valid_o at T+33, result 0xFFFFFFEB; ready_o low T+1..T+33.
- MULH/MULHSU/MULHU with a=b=0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV/DIVU/REM/REMU by zero with a=0x12345678 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x12345678, 0x12345678, each valid_o at T+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0, both at T+1.
- Abort cases:
  - flush_i at T+10 of a DIV -> no valid_o, ready_o high at T+11, previous result_o kept.
  - rst_n low at T+5 -> no valid_o; outputs at reset values on the next cycle.
- Busy handling: valid_i held with new operands during CALC -> ignored; the first result is correct. The held request is accepted in the cycle ready_o returns high, and its result appears XLEN+1 cycles later.
